// File: rtl/sdram_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: FSM encoding, port ids
// and default sizing.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam int AW_DEF      = 26;
    localparam int TIMEOUT_DEF = 255;

    // Read data returned to a requester whose transaction was aborted.
    localparam logic [7:0] RD_ABORT = 8'hFF;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a byte-wide SDRAM controller.
// Port A is the CPU window, port B the block-copy/SD DMA engine. One
// transaction at a time is latched, issued on mem_req, waited for on
// mem_ready (with a timeout abort) and acknowledged to its owner.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic          a_ack,
    output logic [7:0]    a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    output logic          b_ack,
    output logic [7:0]    b_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter value during the TIMEOUT-th WAIT cycle; abort fires there.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e          state_q;
    port_e           gnt_q;
    port_e           last_q;
    logic [CW-1:0]   cnt_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [7:0]      mem_wdata_q;
    logic            a_ack_q;
    logic            b_ack_q;
    logic [7:0]      a_rdata_q;
    logic [7:0]      b_rdata_q;
    logic            err_q;

    port_e           gnt_d;
    logic            wait_ok;
    logic            wait_to;
    logic [7:0]      rd_val;

    // Grant choice in IDLE: a lone requester wins, a tie goes to the port
    // that did not win last time. Also classifies how a WAIT cycle ends;
    // the first WAIT cycle (cnt_q == 0) ignores mem_ready because the
    // controller has not yet had a chance to drop it.
    always_comb begin
        gnt_d   = PORT_A;
        wait_ok = 1'b0;
        wait_to = 1'b0;
        if (b_req && (!a_req || last_q == PORT_A)) begin
            gnt_d = PORT_B;
        end
        if (state_q == ST_WAIT) begin
            wait_ok = (cnt_q != '0) && mem_ready;
            wait_to = !wait_ok && (cnt_q == CNT_LAST);
        end
        rd_val = wait_ok ? mem_rdata : RD_ABORT;
    end

    // Transaction sequencer: every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= PORT_A;
            last_q      <= PORT_B;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        gnt_q       <= gnt_d;
                        last_q      <= gnt_d;
                        mem_we_q    <= (gnt_d == PORT_B) ? b_we    : a_we;
                        mem_addr_q  <= (gnt_d == PORT_B) ? b_addr  : a_addr;
                        mem_wdata_q <= (gnt_d == PORT_B) ? b_wdata : a_wdata;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_ok || wait_to) begin
                        if (!mem_we_q) begin
                            if (gnt_q == PORT_B) b_rdata_q <= rd_val;
                            else                 a_rdata_q <= rd_val;
                        end
                        err_q   <= err_q | wait_to;
                        a_ack_q <= (gnt_q == PORT_A);
                        b_ack_q <= (gnt_q == PORT_B);
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a behavioural SDRAM controller.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int AW = 26;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [7:0]    a_rdata, b_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ready;
    logic          busy, err;

    always #20 clock = ~clock;

    sdram_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
    } tx_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h78;
    endfunction

    // ---------------- behavioural SDRAM controller ----------------
    int         c_lat = 0;      // 0: random latency 2..8
    bit         c_hang = 0;     // never complete
    bit         c_low = 0;      // hold mem_ready low while idle
    logic       c_init;
    logic       c_busy;
    int         c_cnt;
    logic       c_we;
    logic [11:0] c_addr;
    logic [7:0] c_wdata;
    logic [7:0] cmem [0:4095];

    always @(posedge clock) begin
        if (c_init !== 1'b1) begin
            for (int i = 0; i < 4096; i++) cmem[i] <= init_byte(AW'(i));
            c_init <= 1'b1;
        end
        if (reset) begin
            mem_ready <= 1'b1;
            mem_rdata <= 8'h00;
            c_busy    <= 1'b0;
        end else if (mem_req) begin
            mem_ready <= 1'b0;
            c_busy    <= 1'b1;
            c_cnt     <= (c_lat > 0) ? c_lat : int'($urandom_range(2, 8));
            c_we      <= mem_we;
            c_addr    <= mem_addr[11:0];
            c_wdata   <= mem_wdata;
        end else if (c_busy) begin
            if (!c_hang) begin
                if (c_cnt <= 1) begin
                    mem_ready <= 1'b1;
                    c_busy    <= 1'b0;
                    if (c_we) cmem[c_addr] <= c_wdata;
                    else      mem_rdata    <= cmem[c_addr];
                end else begin
                    c_cnt <= c_cnt - 1;
                end
            end
        end else begin
            mem_ready <= !c_low;
        end
    end

    // ---------------- reference model + scoreboard queues ----------------
    logic [7:0] rmem [0:4095];
    logic [7:0] held_a, held_b;
    bit         ref_last;           // 0: A served last, 1: B served last
    bit         ref_err;
    tx_t        txa[$], txb[$];
    tx_t        exp_mem[$];
    logic [7:0] exp_a[$], exp_b[$];
    bit         plan_order[$];
    bit         ack_log[$];
    bit         chk_to_lat = 0;

    task automatic ref_reset();
        held_a = 8'h00; held_b = 8'h00; ref_last = 1'b1; ref_err = 1'b0;
    endtask

    // Both ports keep requesting until their list is exhausted, so every
    // arbitration sees all non-empty ports waiting: serve the one that did
    // not go last, or the only one left.
    task automatic plan(input bit hang);
        int ia, ib;
        bit pa, pb, use_b;
        tx_t t;
        logic [7:0] r;
        ia = 0; ib = 0;
        plan_order.delete();
        while (ia < txa.size() || ib < txb.size()) begin
            pa = (ia < txa.size());
            pb = (ib < txb.size());
            use_b = pb && (!pa || !ref_last);
            t = use_b ? txb[ib] : txa[ia];
            exp_mem.push_back(t);
            if (!t.we) begin
                r = hang ? 8'hFF : rmem[t.addr[11:0]];
                if (use_b) held_b = r; else held_a = r;
            end else if (!hang) begin
                rmem[t.addr[11:0]] = t.wdata;
            end
            if (hang) ref_err = 1'b1;
            if (use_b) exp_b.push_back(held_b); else exp_a.push_back(held_a);
            ref_last = use_b;
            plan_order.push_back(use_b);
            if (use_b) ib++; else ia++;
        end
    endtask

    // ---------------- monitor ----------------
    bit outstanding = 0;
    int mreq_cyc = 0;

    always @(negedge clock) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            if (mem_req) begin
                chk("mem_req_while_waiting", 64'(outstanding), 0);
                outstanding = 1;
                mreq_cyc = cyc;
                chk("mem_req_expected", 64'(exp_mem.size() > 0), 1);
                if (exp_mem.size() > 0) begin
                    tx_t e;
                    e = exp_mem.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(e.we));
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            if (a_ack || b_ack) begin
                outstanding = 0;
                chk("single_ack", 64'(a_ack && b_ack), 0);
                if (chk_to_lat) chk("timeout_latency", 64'(cyc - mreq_cyc), TO);
            end
            if (a_ack) begin
                ack_log.push_back(1'b0);
                chk("a_ack_expected", 64'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) chk("a_rdata", 64'(a_rdata), 64'(exp_a.pop_front()));
            end
            if (b_ack) begin
                ack_log.push_back(1'b1);
                chk("b_ack_expected", 64'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) chk("b_rdata", 64'(b_rdata), 64'(exp_b.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit is_b);
        int n, w;
        tx_t t;
        n = is_b ? txb.size() : txa.size();
        for (int i = 0; i < n; i++) begin
            t = is_b ? txb[i] : txa[i];
            if (is_b) begin b_req = 1; b_we = t.we; b_addr = t.addr; b_wdata = t.wdata; end
            else      begin a_req = 1; a_we = t.we; a_addr = t.addr; a_wdata = t.wdata; end
            w = 0;
            do begin
                @(posedge clock); #1;
                w++;
            end while (!(is_b ? b_ack : a_ack) && w < 300);
            chk(is_b ? "b_ack_in_time" : "a_ack_in_time", 64'(w < 300), 1);
            if (w >= 300) break;
        end
        if (is_b) b_req = 0; else a_req = 0;
    endtask

    task automatic run_batch(input bit hang);
        int w;
        plan(hang);
        ack_log.delete();
        @(posedge clock); #1;
        fork
            drive(1'b0);
            drive(1'b1);
        join
        w = 0;
        while (busy && w < 50) begin @(posedge clock); #1; w++; end
        repeat (2) @(posedge clock);
        #1;
        chk("batch_mem_drained", 64'(exp_mem.size()), 0);
        chk("batch_a_drained", 64'(exp_a.size()), 0);
        chk("batch_b_drained", 64'(exp_b.size()), 0);
        chk("ack_count", 64'(ack_log.size()), 64'(plan_order.size()));
        for (int i = 0; i < ack_log.size() && i < plan_order.size(); i++)
            chk("ack_order", 64'(ack_log[i]), 64'(plan_order[i]));
        chk("err_flag", 64'(err), 64'(ref_err));
        exp_mem.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic do_reset();
        reset = 1; a_req = 0; b_req = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("outputs_in_reset",
            {a_ack, b_ack, a_rdata, b_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, err}, 0);
        reset = 0;
        ref_reset();
        @(posedge clock); #1;
    endtask

    function automatic tx_t mk(input logic we, input int addr, input logic [7:0] d);
        tx_t t;
        t.we = we; t.addr = AW'(addr); t.wdata = d;
        return t;
    endfunction

    task automatic rand_lists(input int na, input int nb);
        txa.delete(); txb.delete();
        for (int i = 0; i < na; i++)
            txa.push_back(mk($urandom_range(0, 1), $urandom_range(0, 31), 8'($urandom)));
        for (int i = 0; i < nb; i++)
            txb.push_back(mk($urandom_range(0, 1), $urandom_range(0, 31), 8'($urandom)));
    endtask

    initial begin
        int w;
        for (int i = 0; i < 4096; i++) rmem[i] = init_byte(AW'(i));
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        do_reset();
        chk("idle_after_reset", {busy, err, a_ack, b_ack, mem_req}, 0);

        // Lone A read, fixed controller latency.
        c_lat = 6;
        txa.delete(); txb.delete();
        txa.push_back(mk(1'b0, 'h123, 8'h00));
        run_batch(1'b0);
        chk("a_read_0x123", 64'(a_rdata), 64'h5A);

        // Simultaneous A write / B read straight from reset: A first.
        c_lat = 0;
        do_reset();
        txa.delete(); txb.delete();
        txa.push_back(mk(1'b1, 'h10, 8'hC3));
        txb.push_back(mk(1'b0, 'h20, 8'h00));
        run_batch(1'b0);

        // Saturated dual requests, 4 + 4: strict alternation.
        rand_lists(4, 4);
        run_batch(1'b0);

        // mem_ready held low before ISSUE: mem_* stay put, no mem_req.
        c_low = 1;
        @(posedge clock); @(posedge clock); #1;
        txa.delete(); txb.delete();
        txa.push_back(mk(1'b1, 'h55, 8'hA7));
        fork
            run_batch(1'b0);
            begin
                w = 0;
                while (!busy && w < 20) begin @(posedge clock); #1; w++; end
                chk("hold_busy_seen", 64'(busy), 1);
                for (int i = 0; i < 10; i++) begin
                    chk("hold_no_mem_req", 64'(mem_req), 0);
                    chk("hold_mem_addr", 64'(mem_addr), 'h55);
                    chk("hold_mem_we", 64'(mem_we), 1);
                    chk("hold_mem_wdata", 64'(mem_wdata), 'hA7);
                    @(posedge clock); #1;
                end
                c_low = 0;
            end
        join

        // Random traffic, uneven lists, random latencies.
        rand_lists(8, 5);
        run_batch(1'b0);

        // Hung controller: abort after TO wait cycles, sticky err.
        c_hang = 1; chk_to_lat = 1;
        txa.delete(); txb.delete();
        txa.push_back(mk(1'b0, 'h40, 8'h00));
        run_batch(1'b1);
        chk("timeout_rdata", 64'(a_rdata), 64'hFF);
        c_hang = 0; chk_to_lat = 0;
        repeat (20) @(posedge clock);
        rand_lists(3, 3);
        run_batch(1'b0);
        chk("err_sticky", 64'(err), 1);

        // Reset during WAIT: outputs clear, no ack, A wins next tie.
        c_hang = 1;
        @(posedge clock); #1;
        a_req = 1; a_we = 0; a_addr = AW'('h66); a_wdata = 0;
        exp_mem.push_back(mk(1'b0, 'h66, 8'h00));
        w = 0;
        while (!mem_req && w < 20) begin @(posedge clock); #1; w++; end
        chk("mid_wait_mem_req_seen", 64'(mem_req), 1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1; a_req = 0;
        @(posedge clock); #1;
        chk("outputs_after_mid_reset",
            {a_ack, b_ack, a_rdata, b_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, err}, 0);
        reset = 0; c_hang = 0;
        ref_reset();
        repeat (5) @(posedge clock);
        #1;
        chk("no_ack_after_mid_reset", 64'(exp_a.size() + exp_b.size() + exp_mem.size()), 0);
        txa.delete(); txb.delete();
        txa.push_back(mk(1'b0, 'h7, 8'h00));
        txb.push_back(mk(1'b0, 'h8, 8'h00));
        run_batch(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
